// File: rtl/instr_decode.sv
// Decode stage for RV32I OP, OP-IMM and LUI: single-entry output register with
// valid/ready backpressure, flush, and a saturating illegal-instruction counter.
module instr_decode #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic             out_alu_en,
  output logic             out_src_sel,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;

  logic             d_legal;
  logic [2:0]       d_funct3;
  logic [6:0]       d_funct7;
  logic             d_src_sel;
  logic [XLEN-1:0]  d_imm;
  logic [REG_W-1:0] d_rs1;
  logic [REG_W-1:0] d_rs2;
  logic [REG_W-1:0] d_rd;
  logic             d_rd_we;

  logic             accept;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];

  // Combinational decode of the presented instruction word.
  always_comb begin
    d_legal   = 1'b0;
    d_funct3  = '0;
    d_funct7  = '0;
    d_src_sel = 1'b0;
    d_imm     = '0;
    d_rs1     = in_instr[19:15];
    d_rs2     = in_instr[24:20];
    d_rd      = in_instr[11:7];

    case (opcode)
      OPC_OP: begin
        d_legal = (f7 == F7_ZERO) ||
                  ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
        if (d_legal) begin
          d_src_sel = 1'b1;
          d_funct3  = f3;
          d_funct7  = f7;
        end
      end
      OPC_OP_IMM: begin
        case (f3)
          F3_SLL:  d_legal = (f7 == F7_ZERO);
          F3_SR:   d_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
          default: d_legal = 1'b1;
        endcase
        if (d_legal) begin
          d_rs2    = '0;
          d_funct3 = f3;
          // Shifts carry a 5-bit shamt and keep funct7 as the shift-type modifier.
          if ((f3 == F3_SLL) || (f3 == F3_SR)) begin
            d_imm    = XLEN'(in_instr[24:20]);
            d_funct7 = f7;
          end else begin
            d_imm    = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
          end
        end
      end
      OPC_LUI: begin
        d_legal = 1'b1;
        d_rs1   = '0;
        d_rs2   = '0;
        d_imm   = {in_instr[31:12], 12'b0};
      end
      default: d_legal = 1'b0;
    endcase

    d_rd_we = d_legal && (d_rd != '0);
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Output bundle register and illegal counter; flush outranks accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_alu_en  <= 1'b0;
      out_src_sel <= 1'b0;
      out_imm     <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_pc      <= in_pc;
      out_funct3  <= d_funct3;
      out_funct7  <= d_funct7;
      out_alu_en  <= d_legal;
      out_src_sel <= d_src_sel;
      out_imm     <= d_imm;
      out_rs1     <= d_rs1;
      out_rs2     <= d_rs2;
      out_rd      <= d_rd;
      out_rd_we   <= d_rd_we;
      out_illegal <= !d_legal;
      if (!d_legal && (illegal_cnt != CNT_MAX)) begin
        illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: a reference decoder predicts each bundle,
// which is queued on accept and compared while held and when consumed.
module tb_instr_decode;

  localparam int unsigned CNT_W = 2;
  localparam logic [31:0] CNT_MAX = 32'(2**CNT_W - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        alu_en;
    logic        src_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;
  } bundle_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic             out_alu_en;
  logic             out_src_sel;
  logic [31:0]      out_imm;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic             out_rd_we;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  int          n_cmp = 0;
  int          n_err = 0;
  bundle_t     q[$];
  logic        mdl_valid = 1'b0;
  logic [31:0] mdl_cnt = '0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  always #5 clk = ~clk;

  instr_decode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_alu_en(out_alu_en),
    .out_src_sel(out_src_sel), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference decoder.
  function automatic bundle_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b;
    logic ok;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = w[31:25];
    f3 = w[14:12];
    b = '0;
    b.pc  = pc;
    b.rs1 = w[19:15];
    b.rs2 = w[24:20];
    b.rd  = w[11:7];
    ok = 1'b0;
    if (w[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (ok) begin b.f3 = f3; b.f7 = f7; b.src_sel = 1'b1; end
    end else if (w[6:0] == 7'h13) begin
      if (f3 == 3'd1)      ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
      else                 ok = 1'b1;
      if (ok) begin
        b.rs2 = 5'd0;
        b.f3  = f3;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          b.imm = {27'd0, w[24:20]};
          b.f7  = f7;
        end else begin
          b.imm = {{20{w[31]}}, w[31:20]};
        end
      end
    end else if (w[6:0] == 7'h37) begin
      ok = 1'b1;
      b.rs1 = 5'd0;
      b.rs2 = 5'd0;
      b.imm = {w[31:12], 12'h000};
    end
    b.alu_en  = ok;
    b.illegal = !ok;
    b.rd_we   = ok && (b.rd != 5'd0);
    return b;
  endfunction

  task automatic compare_bundle(input string tag, input bundle_t e);
    check({tag, ".pc"},      out_pc,              e.pc);
    check({tag, ".funct3"},  32'(out_funct3),     32'(e.f3));
    check({tag, ".funct7"},  32'(out_funct7),     32'(e.f7));
    check({tag, ".alu_en"},  32'(out_alu_en),     32'(e.alu_en));
    check({tag, ".src_sel"}, 32'(out_src_sel),    32'(e.src_sel));
    check({tag, ".imm"},     out_imm,             e.imm);
    check({tag, ".rs1"},     32'(out_rs1),        32'(e.rs1));
    check({tag, ".rs2"},     32'(out_rs2),        32'(e.rs2));
    check({tag, ".rd"},      32'(out_rd),         32'(e.rd));
    check({tag, ".rd_we"},   32'(out_rd_we),      32'(e.rd_we));
    check({tag, ".illegal"}, 32'(out_illegal),    32'(e.illegal));
  endtask

  // One clock: drive inputs, update the model, then sample after the edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic fl, input logic rdy);
    bundle_t b;
    logic acc;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc_ctr;
    flush     = fl;
    out_ready = rdy;
    #1;
    check("in_ready", 32'(in_ready), 32'(!mdl_valid || rdy));
    acc = v && (!mdl_valid || rdy) && !fl && !rst;
    if (rst) begin
      q.delete();
      mdl_valid = 1'b0;
      mdl_cnt   = '0;
    end else if (fl) begin
      if (mdl_valid && q.size() > 0) void'(q.pop_front());
      mdl_valid = 1'b0;
    end else begin
      if (mdl_valid && rdy && q.size() > 0) begin
        b = q.pop_front();
        compare_bundle("consume", b);
      end
      if (acc) begin
        b = ref_dec(ins, pc_ctr);
        q.push_back(b);
        mdl_valid = 1'b1;
        if (b.illegal && mdl_cnt != CNT_MAX) mdl_cnt++;
      end else if (rdy) begin
        mdl_valid = 1'b0;
      end
    end
    if (acc) pc_ctr += 32'd4;
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(mdl_valid));
    check("illegal_cnt", 32'(illegal_cnt), mdl_cnt);
    if (rst) compare_bundle("reset", '0);
    else if (mdl_valid && q.size() > 0) compare_bundle("hold", q[0]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: w = {($urandom_range(0, 2) == 0) ? 7'h20 : (($urandom_range(0, 3) == 0) ? 7'h01 : 7'h00),
              w[24:7], 7'h33};
      1: w = {w[31:7], 7'h13};
      2: w = {($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00, w[24:15],
              ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5, w[11:7], 7'h13};
      3: w = {w[31:7], 7'h37};
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b0, 1'b1);

    step(1'b1, 32'h002081B3, 1'b0, 1'b1);       // ADD x3,x1,x2
    check("add.rd", 32'(out_rd), 32'd3);
    check("add.rs1", 32'(out_rs1), 32'd1);
    check("add.rs2", 32'(out_rs2), 32'd2);
    check("add.src_sel", 32'(out_src_sel), 32'd1);
    check("add.rd_we", 32'(out_rd_we), 32'd1);
    step(1'b1, 32'h407302B3, 1'b0, 1'b1);       // SUB x5,x6,x7
    check("sub.funct7", 32'(out_funct7), 32'h20);
    check("sub.rd", 32'(out_rd), 32'd5);
    step(1'b1, 32'hFFF00093, 1'b0, 1'b1);       // ADDI x1,x0,-1
    check("addi.imm", out_imm, 32'hFFFFFFFF);
    check("addi.src_sel", 32'(out_src_sel), 32'd0);
    step(1'b1, 32'h12345137, 1'b0, 1'b1);       // LUI x2,0x12345
    check("lui.imm", out_imm, 32'h12345000);
    check("lui.rs1", 32'(out_rs1), 32'd0);
    step(1'b1, 32'h00000013, 1'b0, 1'b1);       // ADDI x0,x0,0
    check("nop.rd_we", 32'(out_rd_we), 32'd0);
    check("nop.alu_en", 32'(out_alu_en), 32'd1);
    step(1'b1, 32'h00000000, 1'b0, 1'b1);
    check("ill0.cnt", 32'(illegal_cnt), 32'd1);
    check("ill0.illegal", 32'(out_illegal), 32'd1);
    step(1'b1, 32'h0200D093, 1'b0, 1'b1);       // SRLI with bad funct7
    check("ill1.cnt", 32'(illegal_cnt), 32'd2);
    check("ill1.alu_en", 32'(out_alu_en), 32'd0);

    // Flush of a held bundle and an incoming illegal word.
    step(1'b1, 32'h00000000, 1'b1, 1'b0);
    check("flush.valid", 32'(out_valid), 32'd0);
    check("flush.cnt", 32'(illegal_cnt), 32'd2);

    // Saturation.
    for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b1);
    check("sat.cnt", 32'(illegal_cnt), 32'd3);

    // Stall then stream of four.
    step(1'b1, 32'h002081B3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h407302B3, 1'b0, 1'b0);
    step(1'b1, 32'h407302B3, 1'b0, 1'b1);
    step(1'b1, 32'h12345137, 1'b0, 1'b1);
    step(1'b1, 32'hFFF00093, 1'b0, 1'b1);
    step(1'b1, 32'h0050D213, 1'b0, 1'b1);       // SRLI x4,x1,5
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-stall.
    step(1'b1, 32'h002081B3, 1'b0, 1'b1);
    step(1'b1, 32'h407302B3, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b1, 32'h407302B3, 1'b0, 1'b0);
    rst = 1'b0;

    // Randomised traffic.
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) != 0);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- Decode stage of the RISC-V core. Accepts fetched 32-bit instructions over a valid/ready handshake.
- Produces registered control for the ALU and register file: funct3, funct7, alu_en, src_sel, immediate, register indices, write enable.
- Supports RV32I OP, OP-IMM and LUI. Any other encoding is flagged illegal and counted.
- Sits between fetch and the execute stage. Single-entry pipeline register with backpressure and flush.

Parameters:
CNT_W, 16, width of the saturating illegal-instruction counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard held and incoming instruction this cycle
in_valid  input  1  fetch presents in_instr/in_pc
in_ready  output  1  decode can accept this cycle
in_instr  input  32  raw instruction word
in_pc  input  32  instruction address
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute consumes bundle this cycle
out_pc  output  32  registered in_pc
out_funct3  output  3  ALU function code
out_funct7  output  7  ALU function modifier
out_alu_en  output  1  ALU enable
out_src_sel  output  1  1 = rs2 operand, 0 = immediate operand
out_imm  output  32  decoded immediate
out_rs1  output  5  source register 1 index
out_rs2  output  5  source register 2 index
out_rd  output  5  destination register index
out_rd_we  output  1  register write enable
out_illegal  output  1  instruction not supported/decodable
illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset:
  - rst=1 at a clock edge clears all outputs and illegal_cnt to 0 (out_valid=0).
  - in_ready=1 from the first cycle after reset.
  - Reset mid-transfer drops the held bundle silently.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready && !flush.
  - On accept, the bundle is registered: latency 1 cycle, out_valid=1 next cycle.
  - If out_valid && out_ready && no accept, out_valid drops to 0.
  - While out_valid && !out_ready, every out_* holds stable.
- Flush has priority over everything except rst: out_valid=0 next cycle, input not accepted, illegal_cnt unchanged.
- Full throughput: back-to-back accepts with out_ready=1 produce one bundle per cycle with no bubbles.
- Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], f3=instr[14:12], f7=instr[31:25].
- OP (0110011):
  - Legal if f7=0000000, or f7=0100000 with f3 in {000,101}.
  - src_sel=1, funct3=f3, funct7=f7, imm=0.
- OP-IMM (0010011):
  - src_sel=0, rs2=0, funct3=f3.
  - f3=001: imm = zero-extended instr[24:20]; legal only if f7=0000000; funct7=f7.
  - f3=101: imm = zero-extended instr[24:20]; legal only if f7 in {0000000,0100000}; funct7=f7.
  - Other f3: imm = sign-extend instr[31:20]; funct7=0000000.
- LUI (0110111):
  - imm={instr[31:12],12'b0}, rs1=0, rs2=0, funct3=000, funct7=0, src_sel=0.
  - Execute computes x0+imm.
- Legal instruction: alu_en=1, illegal=0, rd_we=(rd!=0).
- Illegal instruction (any other opcode or failed legality check):
  - illegal=1, alu_en=0, rd_we=0, funct3=0, funct7=0, imm=0, src_sel=0; register fields still extracted.
  - Bundle still delivered so the core can trap.
  - illegal_cnt increments on accept and saturates at all-ones.
- No internal state besides the output register and the counter. Simultaneous accept and consume updates the register in place.

Test Plan:
- Reset then in_instr=0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle out_valid=1, funct3=0, funct7=0x00, src_sel=1, rs1=1, rs2=2, rd=3, rd_we=1, alu_en=1, illegal=0.
- 0x407302B3 (SUB x5,x6,x7) -> funct7=0x20, funct3=0, src_sel=1, rd=5; then 0xFFF00093 (ADDI x1,x0,-1) -> imm=0xFFFFFFFF, src_sel=0, funct7=0, rd=1.
- 0x12345137 (LUI x2,0x12345) -> imm=0x12345000, rs1=0, funct3=0, src_sel=0, rd_we=1; ADDI x0,x0,0 (0x00000013) -> rd_we=0, alu_en=1.
- 0x00000000, then 0x0200D093 (SRLI with f7=0000001) -> both illegal=1, alu_en=0, rd_we=0; illegal_cnt 0->1->2. Preload to all-ones via 2^CNT_W illegals (CNT_W=2 build) -> stays 3.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no extra accepts. out_ready=1 -> stream of 4 instructions emerges in order, one per cycle.
- flush=1 while out_valid=1 and in_valid=1 (illegal word) -> out_valid=0 next cycle, illegal_cnt unchanged; rst asserted mid-stall -> all outputs 0 the following cycle.
